// File: rtl/lcd_update_arbiter.sv
// lcd_update_arbiter: decides which text goes to the 2x16 LCD driver.
// RX echoes pre-empt sensor updates and are then held on screen for
// HOLD_CYCLES before sensor updates resume. A missing lcd_done is
// caught by a watchdog.
module lcd_update_arbiter #(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int DONE_TIMEOUT = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_req,
  input  logic [127:0] rx_row1,
  input  logic         sens_req,
  input  logic [127:0] sens_row1,
  input  logic [127:0] sens_row2,
  input  logic         lcd_busy,
  input  logic         lcd_done,
  output logic         lcd_start,
  output logic [127:0] lcd_row1,
  output logic [127:0] lcd_row2,
  output logic         rx_ovf,
  output logic         lcd_err,
  output logic [1:0]   state_o
);

  localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(DONE_TIMEOUT - 1);
  localparam logic [127:0]  ROW1_RST  = "  Cold Storage  ";
  localparam logic [127:0]  ROW2_RST  = "     Welcome    ";

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_WAIT = 2'd2, S_HOLD = 2'd3} state_t;

  state_t        state;
  logic          src_rx;
  logic [127:0]  rx_buf, sens_buf1, sens_buf2;
  logic          rx_pend, sens_pend;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] to_cnt;
  logic          fire, rx_fire, sens_fire;

  assign fire      = (state == S_LOAD) && !lcd_busy;
  assign rx_fire   = fire && src_rx;
  assign sens_fire = fire && !src_rx;
  assign state_o   = state;

  // Request capture: a new request always wins over a same-cycle consume.
  // Overflow only counts when an undisplayed RX text is really lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_buf    <= '0;
      sens_buf1 <= '0;
      sens_buf2 <= '0;
      rx_pend   <= 1'b0;
      sens_pend <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      if (rx_req) begin
        rx_buf  <= rx_row1;
        rx_pend <= 1'b1;
        if (rx_pend && !rx_fire) rx_ovf <= 1'b1;
      end else if (rx_fire) begin
        rx_pend <= 1'b0;
      end
      if (sens_req) begin
        sens_buf1 <= sens_row1;
        sens_buf2 <= sens_row2;
        sens_pend <= 1'b1;
      end else if (sens_fire) begin
        sens_pend <= 1'b0;
      end
    end
  end

  // Arbitration FSM. IDLE/HOLD also look at the raw request pulses so a
  // request reaches lcd_start two cycles later (capture+LOAD, then fire).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      src_rx    <= 1'b0;
      lcd_start <= 1'b0;
      lcd_row1  <= ROW1_RST;
      lcd_row2  <= ROW2_RST;
      lcd_err   <= 1'b0;
      hold_cnt  <= '0;
      to_cnt    <= '0;
    end else begin
      lcd_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_pend || rx_req) begin
            state  <= S_LOAD;
            src_rx <= 1'b1;
          end else if (sens_pend || sens_req) begin
            state  <= S_LOAD;
            src_rx <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!lcd_busy) begin
            lcd_row1  <= src_rx ? rx_buf : sens_buf1;
            if (!src_rx) lcd_row2 <= sens_buf2;
            lcd_start <= 1'b1;
            to_cnt    <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lcd_done) begin
            to_cnt <= '0;
            if (src_rx) begin
              hold_cnt <= HOLD_LAST;
              state    <= S_HOLD;
            end else begin
              state <= S_IDLE;
            end
          end else if (to_cnt == TO_LAST) begin
            to_cnt  <= '0;
            lcd_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_HOLD: begin
          // sensor updates stay pending here; only RX may cut the hold short
          if (rx_pend || rx_req) begin
            hold_cnt <= '0;
            src_rx   <= 1'b1;
            state    <= S_LOAD;
          end else if (hold_cnt == '0) begin
            state <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_update_arbiter.sv
// Bench for lcd_update_arbiter: expected LCD text is queued when a request
// is driven and checked by a monitor whenever lcd_start fires.
module tb_lcd_update_arbiter;

  localparam logic [127:0] COLD   = "  Cold Storage  ";
  localparam logic [127:0] WELC   = "     Welcome    ";
  localparam logic [127:0] TEMP05 = "Temp: 05 C      ";
  localparam logic [127:0] HUMI20 = "Humi: 20%       ";
  localparam logic [127:0] TEMP07 = "Temp: 07 C      ";
  localparam logic [127:0] HUMI33 = "Humi: 33%       ";
  localparam logic [127:0] TEMP11 = "Temp: 11 C      ";
  localparam logic [127:0] HUMI44 = "Humi: 44%       ";
  localparam logic [127:0] TEMP12 = "Temp: 12 C      ";
  localparam logic [127:0] HUMI45 = "Humi: 45%       ";
  localparam logic [127:0] RXA    = "RX: hello world ";
  localparam logic [127:0] RXB1   = "RX: first msg   ";
  localparam logic [127:0] RXB2   = "RX: second msg  ";
  localparam logic [127:0] RXC    = "RX: before hold ";
  localparam logic [127:0] RXD    = "RX: preempted   ";
  localparam logic [127:0] RXE    = "RX: reset me    ";

  typedef struct {
    logic         is_rx;
    logic [127:0] r1;
    logic [127:0] r2;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_req = 1'b0, sens_req = 1'b0, lcd_busy = 1'b0, lcd_done = 1'b0;
  logic [127:0] rx_row1 = '0, sens_row1 = '0, sens_row2 = '0;
  logic         lcd_start, rx_ovf, lcd_err;
  logic [127:0] lcd_row1, lcd_row2;
  logic [1:0]   state_o;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_fail = 0;

  lcd_update_arbiter #(.HOLD_CYCLES(8), .DONE_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rx_req(rx_req), .rx_row1(rx_row1),
    .sens_req(sens_req), .sens_row1(sens_row1), .sens_row2(sens_row2),
    .lcd_busy(lcd_busy), .lcd_done(lcd_done),
    .lcd_start(lcd_start), .lcd_row1(lcd_row1), .lcd_row2(lcd_row2),
    .rx_ovf(rx_ovf), .lcd_err(lcd_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every lcd_start must match the oldest queued request.
  initial begin : monitor
    exp_t         me;
    logic [127:0] last_r2, want_r2;
    last_r2 = WELC;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_r2 = WELC;
      end else if (lcd_start) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL start_unexpected: lcd_start=1 row1='%s' with nothing queued", lcd_row1);
        end else begin
          me = sb.pop_front();
          want_r2 = me.is_rx ? last_r2 : me.r2;
          if (lcd_row1 !== me.r1 || lcd_row2 !== want_r2) begin
            n_fail++;
            $display("FAIL rows_at_start: got '%s'/'%s' expected '%s'/'%s'",
                     lcd_row1, lcd_row2, me.r1, want_r2);
          end
          last_r2 = want_r2;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_done();
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, output int cyc, output bit found);
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < max_cyc) begin
      tick();
      cyc++;
      if (lcd_start) found = 1'b1;
    end
  endtask

  task automatic push(input logic is_rx, input logic [127:0] r1, input logic [127:0] r2);
    exp_t e;
    e.is_rx = is_rx; e.r1 = r1; e.r2 = r2;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_chk++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_chk++; if (lcd_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", lcd_start); end
    n_chk++; if (lcd_row1 !== COLD) begin n_fail++; $display("FAIL reset_row1: got '%s' expected '%s'", lcd_row1, COLD); end
    n_chk++; if (lcd_row2 !== WELC) begin n_fail++; $display("FAIL reset_row2: got '%s' expected '%s'", lcd_row2, WELC); end
    n_chk++; if (rx_ovf !== 1'b0 || lcd_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b err=%b expected 0/0", rx_ovf, lcd_err); end
    rst = 1'b0;
    repeat (2) tick();
    n_chk++; if (state_o !== 2'd0 || lcd_start !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got state=%0d start=%b expected 0/0", state_o, lcd_start); end
  endtask

  task automatic test_sens();
    tick();
    sens_row1 = TEMP05; sens_row2 = HUMI20; sens_req = 1'b1;
    push(1'b0, TEMP05, HUMI20);
    tick();
    sens_req = 1'b0;
    n_chk++; if (lcd_start !== 1'b0 || state_o !== 2'd1) begin n_fail++; $display("FAIL sens_lat1: got start=%b state=%0d expected 0/1", lcd_start, state_o); end
    tick();
    n_chk++; if (lcd_start !== 1'b1 || state_o !== 2'd2) begin n_fail++; $display("FAIL sens_lat2: got start=%b state=%0d expected 1/2", lcd_start, state_o); end
    pulse_done();
    n_chk++; if (state_o !== 2'd0 || lcd_start !== 1'b0) begin n_fail++; $display("FAIL sens_done_idle: got state=%0d start=%b expected 0/0", state_o, lcd_start); end
  endtask

  task automatic test_priority();
    int cyc; bit found;
    tick();
    rx_row1 = RXA; rx_req = 1'b1;
    sens_row1 = TEMP07; sens_row2 = HUMI33; sens_req = 1'b1;
    push(1'b1, RXA, '0);
    push(1'b0, TEMP07, HUMI33);
    tick();
    rx_req = 1'b0; sens_req = 1'b0;
    wait_start(10, cyc, found);
    n_chk++; if (!found || lcd_row1 !== RXA) begin n_fail++; $display("FAIL prio_rx_first: got found=%b row1='%s' expected 1/'%s'", found, lcd_row1, RXA); end
    pulse_done();
    n_chk++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL prio_hold: got state=%0d expected 3", state_o); end
    wait_start(30, cyc, found);
    n_chk++; if (!found || cyc < 8) begin n_fail++; $display("FAIL prio_hold_gap: got found=%b cycles=%0d expected found and >=8", found, cyc); end
    pulse_done();
    n_chk++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL prio_sens_idle: got state=%0d expected 0", state_o); end
  endtask

  task automatic test_overflow();
    int cyc, k; bit found;
    lcd_busy = 1'b1;
    tick();
    rx_row1 = RXB1; rx_req = 1'b1;
    tick();
    rx_req = 1'b0;
    n_chk++; if (rx_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_single: got %b expected 0", rx_ovf); end
    tick();
    rx_row1 = RXB2; rx_req = 1'b1;
    push(1'b1, RXB2, '0);
    tick();
    rx_req = 1'b0;
    n_chk++; if (rx_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", rx_ovf); end
    repeat (3) tick();
    n_chk++; if (state_o !== 2'd1 || lcd_start !== 1'b0) begin n_fail++; $display("FAIL busy_stall: got state=%0d start=%b expected 1/0", state_o, lcd_start); end
    lcd_busy = 1'b0;
    wait_start(5, cyc, found);
    n_chk++; if (!found) begin n_fail++; $display("FAIL ovf_start: got no lcd_start expected one within 5 cycles"); end
    pulse_done();
    k = 0;
    while (state_o !== 2'd0 && k < 20) begin tick(); k++; end
    n_chk++; if (state_o !== 2'd0 || rx_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_end: got state=%0d ovf=%b expected 0/1", state_o, rx_ovf); end
  endtask

  task automatic test_preempt();
    int cyc, hc; bit found;
    tick();
    rx_row1 = RXC; rx_req = 1'b1;
    push(1'b1, RXC, '0);
    tick();
    rx_req = 1'b0;
    wait_start(5, cyc, found);
    n_chk++; if (!found) begin n_fail++; $display("FAIL pre_first_start: got none expected lcd_start"); end
    pulse_done();    // HOLD, count 7
    tick();          // count 6
    tick();          // count 5
    rx_row1 = RXD; rx_req = 1'b1;
    push(1'b1, RXD, '0);
    tick();
    rx_req = 1'b0;
    n_chk++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL pre_load: got state=%0d expected 1", state_o); end
    tick();
    n_chk++; if (lcd_start !== 1'b1 || state_o !== 2'd2) begin n_fail++; $display("FAIL pre_start: got start=%b state=%0d expected 1/2", lcd_start, state_o); end
    pulse_done();
    hc = 0;
    while (state_o === 2'd3 && hc < 30) begin hc++; tick(); end
    n_chk++; if (hc != 8 || state_o !== 2'd0) begin n_fail++; $display("FAIL pre_hold_len: got %0d hold cycles state=%0d expected 8/0", hc, state_o); end
  endtask

  task automatic test_timeout();
    int cyc; bit found;
    n_chk++; if (lcd_err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b expected 0", lcd_err); end
    tick();
    sens_row1 = TEMP11; sens_row2 = HUMI44; sens_req = 1'b1;
    push(1'b0, TEMP11, HUMI44);
    tick();
    sens_req = 1'b0;
    wait_start(5, cyc, found);
    n_chk++; if (!found) begin n_fail++; $display("FAIL to_start: got none expected lcd_start"); end
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) begin
        sens_row1 = TEMP12; sens_row2 = HUMI45; sens_req = 1'b1;
        push(1'b0, TEMP12, HUMI45);
      end
      if (k == 2) sens_req = 1'b0;
    end
    n_chk++; if (state_o !== 2'd2 || lcd_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got state=%0d err=%b expected 2/0", state_o, lcd_err); end
    tick();
    n_chk++; if (state_o !== 2'd0 || lcd_err !== 1'b1) begin n_fail++; $display("FAIL to_fire: got state=%0d err=%b expected 0/1", state_o, lcd_err); end
    wait_start(5, cyc, found);
    n_chk++; if (!found) begin n_fail++; $display("FAIL to_pending_served: got none expected lcd_start"); end
    pulse_done();
    n_chk++; if (state_o !== 2'd0 || lcd_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got state=%0d err=%b expected 0/1", state_o, lcd_err); end
  endtask

  task automatic test_reset_mid();
    int cyc, starts; bit found;
    tick();
    rx_row1 = RXE; rx_req = 1'b1;
    push(1'b1, RXE, '0);
    tick();
    rx_req = 1'b0;
    wait_start(5, cyc, found);
    tick(); tick();
    n_chk++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL rm_in_wait: got state=%0d expected 2", state_o); end
    #1 rst = 1'b1;
    #1;
    n_chk++; if (state_o !== 2'd0 || lcd_start !== 1'b0) begin n_fail++; $display("FAIL rm_async: got state=%0d start=%b expected 0/0", state_o, lcd_start); end
    n_chk++; if (lcd_row1 !== COLD || lcd_row2 !== WELC) begin n_fail++; $display("FAIL rm_rows: got '%s'/'%s' expected '%s'/'%s'", lcd_row1, lcd_row2, COLD, WELC); end
    n_chk++; if (rx_ovf !== 1'b0 || lcd_err !== 1'b0) begin n_fail++; $display("FAIL rm_flags: got ovf=%b err=%b expected 0/0", rx_ovf, lcd_err); end
    tick(); tick();
    rst = 1'b0;
    pulse_done();    // stray done outside WAIT
    starts = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (lcd_start) starts++;
    end
    n_chk++; if (starts != 0 || state_o !== 2'd0) begin n_fail++; $display("FAIL rm_quiet: got %0d starts state=%0d expected 0/0", starts, state_o); end
  endtask

  initial begin : main
    test_reset();
    test_sens();
    test_priority();
    test_overflow();
    test_preempt();
    test_timeout();
    test_reset_mid();
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drained: got %0d entries left expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
